// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
// Holds the occupancy states and the RISC-V bubble encoding.
package pipe_pkg;

    localparam logic [31:0] RV_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stage performance counters.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register, single entry or two-entry skid.
// Empty stages present a NOP bubble downstream.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          SKID      = 1,
    parameter logic [31:0] NOP_VALUE = RV_NOP,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [DATA_W-1:0] NOP_D = DATA_W'(NOP_VALUE);

    stage_state_t      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept, consume;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_valid ? main_q : NOP_D;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Skid mode decodes ready from state only, cutting the out_ready path.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (state_q != TWO);
        end else begin : g_single
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = TWO;
                    skid_d  = in_data;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (!out_valid),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, single-entry and
// narrow-counter instances driven through a linear step sequence.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // SKID=1 instance
    logic        rst1, iv1, fl1, or1;
    logic [31:0] id1;
    logic        ir1, ov1;
    logic [31:0] od1;
    logic [15:0] sc1, bc1;

    // SKID=0 instance
    logic        rst0, iv0, fl0, or0;
    logic [31:0] id0;
    logic        ir0, ov0;
    logic [31:0] od0;
    logic [15:0] sc0, bc0;

    // CNT_W=4 instance
    logic        rsts, ivs, fls, ors;
    logic [31:0] ids;
    logic        irs, ovs;
    logic [31:0] ods;
    logic [3:0]  scs, bcs;

    pipe_stage_reg #(.SKID(1)) dut1 (
        .clk(clk), .reset(rst1), .in_valid(iv1), .in_data(id1),
        .in_ready(ir1), .flush(fl1), .out_valid(ov1),
        .out_data(od1), .out_ready(or1), .stall_cnt(sc1),
        .bubble_cnt(bc1)
    );

    pipe_stage_reg #(.SKID(0)) dut0 (
        .clk(clk), .reset(rst0), .in_valid(iv0), .in_data(id0),
        .in_ready(ir0), .flush(fl0), .out_valid(ov0),
        .out_data(od0), .out_ready(or0), .stall_cnt(sc0),
        .bubble_cnt(bc0)
    );

    pipe_stage_reg #(.SKID(1), .CNT_W(4)) duts (
        .clk(clk), .reset(rsts), .in_valid(ivs), .in_data(ids),
        .in_ready(irs), .flush(fls), .out_valid(ovs),
        .out_data(ods), .out_ready(ors), .stall_cnt(scs),
        .bubble_cnt(bcs)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams 0..99 through one instance with random out_ready.
    // sel=1 drives the skid instance, sel=0 the single-entry one.
    task automatic stream(input bit sel);
        int nin, nout, occ, cyc;
        bit acc, con, r, exp_rdy, rdy;
        nin = 0; nout = 0; occ = 0; cyc = 0;
        while (nout < 100 && cyc < 2000) begin
            r = 1'($urandom_range(0, 1));
            if (sel) begin
                iv1 = (nin < 100); id1 = nin; or1 = r;
            end else begin
                iv0 = (nin < 100); id0 = nin; or0 = r;
            end
            #1;
            if (sel) begin
                exp_rdy = (occ != 2);
                chk("s1_rdy", {31'd0, ir1}, {31'd0, exp_rdy});
                // flipping out_ready must not move in_ready
                or1 = !r;
                #1;
                chk("s1_nocomb", {31'd0, ir1}, {31'd0, exp_rdy});
                or1 = r;
                #1;
                rdy = ir1;
                acc = iv1 && rdy;
                con = ov1 && or1;
                if (con) chk("s1_data", od1, nout);
            end else begin
                exp_rdy = (occ == 0) || r;
                chk("s0_rdy", {31'd0, ir0}, {31'd0, exp_rdy});
                rdy = ir0;
                acc = iv0 && rdy;
                con = ov0 && or0;
                if (con) chk("s0_data", od0, nout);
            end
            if (con) nout++;
            if (acc) nin++;
            occ = occ + int'(acc) - int'(con);
            step();
            cyc++;
        end
        chk(sel ? "s1_count" : "s0_count", nout, 100);
        if (sel) begin
            iv1 = 0; or1 = 0;
        end else begin
            iv0 = 0; or0 = 0;
        end
    endtask

    initial begin
        rst1 = 1; iv1 = 0; fl1 = 0; or1 = 0; id1 = 0;
        rst0 = 1; iv0 = 0; fl0 = 0; or0 = 0; id0 = 0;
        rsts = 1; ivs = 0; fls = 0; ors = 0; ids = 0;
        step();
        step();

        // reset state
        chk("rst_ov", {31'd0, ov1}, 0);
        chk("rst_od", od1, 32'h00000013);
        chk("rst_sc", {16'd0, sc1}, 0);
        chk("rst_bc", {16'd0, bc1}, 0);
        chk("rst_ir1", {31'd0, ir1}, 1);
        chk("rst_ir0", {31'd0, ir0}, 1);
        rst1 = 0; rst0 = 0; rsts = 0;

        // single accept
        iv1 = 1; id1 = 32'hA5A5A5A5; or1 = 1;
        step();
        chk("one_ov", {31'd0, ov1}, 1);
        chk("one_od", od1, 32'hA5A5A5A5);
        chk("one_bc", {16'd0, bc1}, 1);
        iv1 = 0;
        step();
        chk("drain_ov", {31'd0, ov1}, 0);
        chk("drain_od", od1, 32'h00000013);

        // skid fill
        or1 = 0; iv1 = 1; id1 = 32'h11;
        step();
        chk("fill1_od", od1, 32'h11);
        chk("fill1_ir", {31'd0, ir1}, 1);
        id1 = 32'h22;
        step();
        chk("fill2_ir", {31'd0, ir1}, 0);
        chk("fill2_od", od1, 32'h11);
        iv1 = 0;
        step();
        chk("hold_od", od1, 32'h11);
        chk("hold_ov", {31'd0, ov1}, 1);
        chk("hold_sc", {16'd0, sc1}, 2);
        or1 = 1;
        step();
        chk("pop2_od", od1, 32'h22);
        step();
        chk("pop_end_ov", {31'd0, ov1}, 0);
        chk("pop_sc", {16'd0, sc1}, 2);
        chk("pop_bc", {16'd0, bc1}, 2);

        // flush from TWO with a competing push
        or1 = 0; iv1 = 1; id1 = 32'h11;
        step();
        id1 = 32'h22;
        step();
        chk("fl_two_ir", {31'd0, ir1}, 0);
        fl1 = 1; id1 = 32'h33;
        step();
        chk("fl_ov", {31'd0, ov1}, 0);
        chk("fl_od", od1, 32'h00000013);
        chk("fl_ir", {31'd0, ir1}, 1);
        fl1 = 0; iv1 = 0; or1 = 1;
        step();
        chk("fl_after_ov", {31'd0, ov1}, 0);
        chk("fl_sc_kept", {16'd0, sc1}, 4);
        chk("fl_bc", {16'd0, bc1}, 4);

        // flush in ONE drops the payload accepted that cycle
        iv1 = 1; id1 = 32'h44;
        step();
        chk("fl1_od", od1, 32'h44);
        or1 = 0; fl1 = 1; id1 = 32'h55;
        #1;
        chk("fl1_ir", {31'd0, ir1}, 1);
        step();
        fl1 = 0; iv1 = 0;
        chk("fl1_ov", {31'd0, ov1}, 0);
        step();
        chk("fl1_after_ov", {31'd0, ov1}, 0);
        chk("fl1_bc", {16'd0, bc1}, 6);

        // saturation: the narrow instance has idled since reset
        rsts = 1;
        step();
        rsts = 0;
        chk("sat_bc0", {28'd0, bcs}, 0);
        repeat (20) step();
        chk("sat_bc", {28'd0, bcs}, 15);
        chk("sat_sc", {28'd0, scs}, 0);

        // streaming
        stream(1'b1);
        stream(1'b0);

        // mid-operation reset in TWO
        or1 = 0; iv1 = 1; id1 = 32'h66;
        step();
        id1 = 32'h77;
        step();
        iv1 = 0;
        chk("mr_two_ir", {31'd0, ir1}, 0);
        rst1 = 1;
        step();
        rst1 = 0;
        chk("mr_ov", {31'd0, ov1}, 0);
        chk("mr_ir", {31'd0, ir1}, 1);
        chk("mr_sc", {16'd0, sc1}, 0);
        chk("mr_bc", {16'd0, bc1}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width in bits, legal 1..256.
REQ-002 SHALL have parameter SKID, default 1: 0 = single-entry register, 1 = two-entry skid buffer with registered in_ready.
REQ-003 SHALL have parameter NOP_VALUE, default 32'h00000013: value driven on out_data while empty (bubble; addi x0,x0,0), zero-extended or truncated to DATA_W.
REQ-004 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-005 SHALL have port clk  input  1: sole clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1: upstream stage presents a valid payload.
REQ-008 SHALL have port in_data  input  DATA_W: upstream payload.
REQ-009 SHALL have port in_ready  output  1: stage accepts in_data this cycle.
REQ-010 SHALL have port flush  input  1: discard all held and incoming payloads (taken branch or exception).
REQ-011 SHALL have port out_valid  output  1: a payload is presented downstream.
REQ-012 SHALL have port out_data  output  DATA_W: downstream payload, or NOP_VALUE when out_valid=0.
REQ-013 SHALL have port out_ready  input  1: downstream consumes out_data this cycle (low = stall).
REQ-014 SHALL have port stall_cnt  output  CNT_W: cycles with out_valid=1 and out_ready=0.
REQ-015 SHALL have port bubble_cnt  output  CNT_W: cycles with out_valid=0.

Function
REQ-016 SHALL accept a payload when in_valid and in_ready are both 1, and SHALL hand a payload downstream when out_valid and out_ready are both 1.
REQ-017 SHALL, with SKID=0, hold one entry and drive in_ready = !out_valid || out_ready (combinational).
REQ-018 SHALL, with SKID=1, implement the states EMPTY, ONE and TWO, drive in_ready = (state != TWO) from a flop, and have no combinational path from out_ready to in_ready.
REQ-019 SHALL, with SKID=1, make these transitions:
- EMPTY -> ONE on accept.
- ONE -> TWO on accept without consume.
- ONE -> EMPTY on consume without accept.
- ONE -> ONE on simultaneous accept and consume.
- TWO -> ONE on consume; in_ready=0 in TWO, so no accept occurs there.
REQ-020 SHALL deliver payloads in strict FIFO order with no loss and no duplication; the skid entry moves into the main entry in the same cycle that the main entry is consumed.
REQ-021 SHALL give a latency of exactly 1 cycle from accept to out_valid when the stage is empty and not stalled.
REQ-022 SHALL keep out_data stable and out_valid high while out_valid=1 and out_ready=0.
REQ-023 SHALL drive out_data = NOP_VALUE whenever out_valid=0.
REQ-024 SHALL, on flush=1, go to EMPTY (out_valid=0) at the next edge, dropping held entries and any payload accepted in the same cycle; flush takes priority over accept and consume.
REQ-025 SHALL not block in_ready during flush; in_ready follows the current state.
REQ-026 SHALL increment stall_cnt by 1 each cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1.
REQ-027 SHALL increment bubble_cnt by 1 each cycle with out_valid=0, saturating at 2^CNT_W-1.
REQ-028 SHALL clear the counters on reset only; flush does not clear them.

Reset
REQ-029 SHALL, while reset=1 at a rising edge, set state to EMPTY, out_valid=0, out_data=NOP_VALUE, stall_cnt=0 and bubble_cnt=0.
REQ-030 SHALL drive in_ready=1 in the cycle after reset for SKID=1, and SHALL drive in_ready=1 for SKID=0 because out_valid=0.
REQ-031 SHALL discard held payloads on a reset asserted mid-operation, exactly as flush does, and SHALL also clear the counters; counters do not count during reset cycles.

Structure
REQ-032 SHALL place the state enum (EMPTY, ONE, TWO) and the RV_NOP constant (32'h00000013) in the shared package pipe_pkg.
REQ-033 SHALL use one sub-module, sat_counter (CNT_W parameter, inc, clear), instantiated twice for the two counters.
REQ-034 SHALL be a drop-in replacement for the existing IF/ID, ID/EX, EX/MEM and MEM/WB registers via DATA_W.

Verification
REQ-035 SHALL verify single accept: SKID=1, reset, then in_valid=1, in_data=0xA5A5A5A5, out_ready=1 -> out_valid=1 and out_data=0xA5A5A5A5 one cycle later, bubble_cnt=1.
REQ-036 SHALL verify skid fill: SKID=1, out_ready=0, push 0x11 then 0x22 -> in_ready=0 after the second accept; raise out_ready -> 0x11 then 0x22 on consecutive cycles; stall_cnt=2.
REQ-037 SHALL verify flush priority: state TWO holding 0x11 and 0x22, flush=1 together with in_valid=1 and data 0x33 -> next cycle out_valid=0 and out_data=0x00000013; 0x33 never appears.
REQ-038 SHALL verify streaming: SKID=0 and SKID=1, 100 back-to-back payloads 0..99 with out_ready toggled pseudo-randomly -> the output sequence is exactly 0..99 and SKID=1 shows no comb path from out_ready to in_ready.
REQ-039 SHALL verify saturation: CNT_W=4, out_valid=0 for 20 cycles -> bubble_cnt holds at 15.
REQ-040 SHALL verify mid-operation reset: reset in state TWO -> next cycle out_valid=0, in_ready=1 and both counters 0.
